// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA palette stage: default 16-colour table,
// RGB888 type, attribute field positions and the fg/bg index selection helper.
package cga_pkg;

   typedef logic [23:0] rgb888_t;

   localparam int BG_MSB    = 7;
   localparam int FG_MSB    = 3;
   localparam int BLINK_BIT = 7;

   localparam rgb888_t CGA_DEFAULT_PAL [0:15] = '{
      24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
      24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
      24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
      24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
   };

   // In blink mode the top attribute bit is the blink flag, so bg shrinks to 8 colours
   // and a blinking cell shows bg during the active phase.
   function automatic logic [3:0] cga_pick_index(
      input logic [7:0] attr,
      input logic       on,
      input logic       blink_mode,
      input logic       blink_phase
   );
      logic [3:0] fg;
      logic [3:0] bg;
      logic [3:0] idx;
      fg = attr[FG_MSB -: 4];
      if (blink_mode) begin
         bg = {1'b0, attr[BG_MSB-1 -: 3]};
         if (attr[BLINK_BIT] && blink_phase) begin
            idx = bg;
         end else begin
            idx = on ? fg : bg;
         end
      end else begin
         bg  = attr[BG_MSB -: 4];
         idx = on ? fg : bg;
      end
      return idx;
   endfunction

endpackage

// File: rtl/cga_blink_ctr.sv
// Text blink timebase: counts frame pulses and toggles the blink phase every
// BLINK_FRAMES frames.
module cga_blink_ctr
   import cga_pkg::*;
#(
   parameter int BLINK_FRAMES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic frame_i,
   output logic blink_phase_o
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] blink_cnt_r;
   logic             blink_phase_r;

   // Frame counter and phase toggle; with BLINK_FRAMES=1 the counter stays at 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blink_cnt_r   <= {CNT_W{1'b0}};
         blink_phase_r <= 1'b0;
      end else if (frame_i) begin
         if (blink_cnt_r == CNT_LAST) begin
            blink_cnt_r   <= {CNT_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
         end else begin
            blink_cnt_r   <= blink_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign blink_phase_o = blink_phase_r;

endmodule

// File: rtl/cga_palette.sv
// Two-stage CGA attribute-to-RGB stage with sync pass-through and text blink.
// Define CGA_PAL_WR_EN for a writable palette; otherwise the default table is a ROM.
module cga_palette
   import cga_pkg::*;
#(
   parameter int R_W          = 5,
   parameter int G_W          = 6,
   parameter int B_W          = 5,
   parameter int BLINK_FRAMES = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [7:0]     color_i,
   input  logic           on_i,
   input  logic           de_i,
   input  logic           hs_i,
   input  logic           vs_i,
   input  logic           frame_i,
   input  logic           blink_mode_i,
   input  logic           pal_we_i,
   input  logic [3:0]     pal_addr_i,
   input  logic [23:0]    pal_data_i,
   output logic [R_W-1:0] red_o,
   output logic [G_W-1:0] green_o,
   output logic [B_W-1:0] blue_o,
   output logic           de_o,
   output logic           hs_o,
   output logic           vs_o
);

   logic       blink_phase_s;
   logic [3:0] idx_s;
   logic [3:0] idx_r;
   logic       de1_r;
   logic       hs1_r;
   logic       vs1_r;
   rgb888_t    rgb_s;

   cga_blink_ctr #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .frame_i       (frame_i),
      .blink_phase_o (blink_phase_s)
   );

   // Palette index selection from the incoming attribute.
   always_comb begin
      idx_s = 4'h0;
      idx_s = cga_pick_index(color_i, on_i, blink_mode_i, blink_phase_s);
   end

   // Stage 1: register the selected index together with the sync signals.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_r <= 4'h0;
         de1_r <= 1'b0;
         hs1_r <= 1'b0;
         vs1_r <= 1'b0;
      end else begin
         idx_r <= idx_s;
         de1_r <= de_i;
         hs1_r <= hs_i;
         vs1_r <= vs_i;
      end
   end

`ifdef CGA_PAL_WR_EN
   rgb888_t pal_r [0:15];

   // Writable palette; the stage-2 lookup at the same edge still sees the old entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 16; i++) begin
            pal_r[i] <= CGA_DEFAULT_PAL[i];
         end
      end else if (pal_we_i) begin
         pal_r[pal_addr_i] <= pal_data_i;
      end
   end

   assign rgb_s = pal_r[idx_r];
`else
   logic pal_unused_s;

   assign pal_unused_s = ^{pal_we_i, pal_addr_i, pal_data_i};
   assign rgb_s        = CGA_DEFAULT_PAL[idx_r];
`endif

   // Stage 2: lookup, MSB truncation to panel widths, blanking outside DE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         red_o   <= {R_W{1'b0}};
         green_o <= {G_W{1'b0}};
         blue_o  <= {B_W{1'b0}};
         de_o    <= 1'b0;
         hs_o    <= 1'b0;
         vs_o    <= 1'b0;
      end else begin
         if (de1_r) begin
            red_o   <= rgb_s[23 -: R_W];
            green_o <= rgb_s[15 -: G_W];
            blue_o  <= rgb_s[7 -: B_W];
         end else begin
            red_o   <= {R_W{1'b0}};
            green_o <= {G_W{1'b0}};
            blue_o  <= {B_W{1'b0}};
         end
         de_o <= de1_r;
         hs_o <= hs1_r;
         vs_o <= vs1_r;
      end
   end

endmodule

// File: tb/tb_cga_palette.sv
// Scoreboard bench for cga_palette: a 5/6/5 instance and an 8/8/1 instance run
// side by side against a cycle model of the palette, blink counter and pipeline.
module tb_cga_palette;

   logic        clk;
   logic        rst;
   logic [7:0]  color;
   logic        on;
   logic        de;
   logic        hs;
   logic        vs;
   logic        frame;
   logic        bm;
   logic        we;
   logic [3:0]  addr;
   logic [23:0] data;

   logic [4:0]  red_a;
   logic [5:0]  green_a;
   logic [4:0]  blue_a;
   logic        de_a;
   logic        hs_a;
   logic        vs_a;
   logic [7:0]  red_b;
   logic [7:0]  green_b;
   logic [0:0]  blue_b;
   logic        de_b;
   logic        hs_b;
   logic        vs_b;

   cga_palette #(.R_W(5), .G_W(6), .B_W(5), .BLINK_FRAMES(2)) dut (
      .clk_i(clk), .rst_i(rst), .color_i(color), .on_i(on), .de_i(de), .hs_i(hs),
      .vs_i(vs), .frame_i(frame), .blink_mode_i(bm), .pal_we_i(we), .pal_addr_i(addr),
      .pal_data_i(data), .red_o(red_a), .green_o(green_a), .blue_o(blue_a),
      .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a)
   );

   cga_palette #(.R_W(8), .G_W(8), .B_W(1), .BLINK_FRAMES(2)) dut_w (
      .clk_i(clk), .rst_i(rst), .color_i(color), .on_i(on), .de_i(de), .hs_i(hs),
      .vs_i(vs), .frame_i(frame), .blink_mode_i(bm), .pal_we_i(we), .pal_addr_i(addr),
      .pal_data_i(data), .red_o(red_b), .green_o(green_b), .blue_o(blue_b),
      .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b)
   );

   typedef struct packed {
      logic [23:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t        sb_q [$];
   logic [23:0] mpal [16];
   logic [23:0] dflt [16];
   int          mcnt;
   logic        mph;
   int          n_tests;
   int          n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One pixel clock: drive inputs, update the model, then check the output edge.
   task automatic cyc(input logic r, input logic [7:0] c, input logic o, input logic d,
                      input logic h, input logic v, input logic f, input logic b,
                      input logic w, input logic [3:0] a, input logic [23:0] dt);
      exp_t       e;
      logic [3:0] bg;
      logic [3:0] idx;
      @(negedge clk);
      rst = r; color = c; on = o; de = d; hs = h; vs = v;
      frame = f; bm = b; we = w; addr = a; data = dt;
      if (r) begin
         for (int i = 0; i < 16; i++) mpal[i] = dflt[i];
         mcnt = 0;
         mph  = 1'b0;
         sb_q.delete();
         sb_q.push_back('0);
         sb_q.push_back('0);
      end else begin
         if (b) begin
            bg  = {1'b0, c[6:4]};
            idx = (c[7] && mph) ? bg : (o ? c[3:0] : bg);
         end else begin
            idx = o ? c[3:0] : c[7:4];
         end
`ifdef CGA_PAL_WR_EN
         if (w) mpal[a] = dt;
`endif
         e.rgb = d ? mpal[idx] : 24'h000000;
         e.de  = d;
         e.hs  = h;
         e.vs  = v;
         sb_q.push_back(e);
         if (f) begin
            if (mcnt == 1) begin
               mcnt = 0;
               mph  = ~mph;
            end else begin
               mcnt = mcnt + 1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("queue_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("red",     32'(red_a),   32'(e.rgb[23:19]));
         chk("green",   32'(green_a), 32'(e.rgb[15:10]));
         chk("blue",    32'(blue_a),  32'(e.rgb[7:3]));
         chk("sync",    32'({de_a, hs_a, vs_a}), 32'({e.de, e.hs, e.vs}));
         chk("red8",    32'(red_b),   32'(e.rgb[23:16]));
         chk("green8",  32'(green_b), 32'(e.rgb[15:8]));
         chk("blue1",   32'(blue_b),  32'(e.rgb[7]));
         chk("sync_w",  32'({de_b, hs_b, vs_b}), 32'({e.de, e.hs, e.vs}));
      end
   endtask

   task automatic pix(input logic [7:0] c, input logic o, input logic b, input logic f);
      cyc(1'b0, c, o, 1'b1, 1'b0, 1'b0, f, b, 1'b0, 4'h0, 24'h0);
   endtask

   initial begin
      logic [4:0] pat;
      n_tests = 0;
      n_fail  = 0;
      dflt = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
               24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
               24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
               24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
      mcnt = 0;
      mph  = 1'b0;
      rst = 1'b1; color = 8'h00; on = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
      frame = 1'b0; bm = 1'b0; we = 1'b0; addr = 4'h0; data = 24'h0;

      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);

      // Basic fg/bg lookup
      pix(8'h1E, 1'b1, 1'b0, 1'b0);
      pix(8'h1E, 1'b0, 1'b0, 1'b0);
      pix(8'h1E, 1'b1, 1'b0, 1'b0);

      // Sync alignment with shared pattern, then blanking outside DE
      pat = 5'b01101;
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 8'h1E, 1'b1, pat[i], pat[i], pat[i], 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);
      cyc(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);
      cyc(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);

      // Blink: frame pulse every third cycle
      for (int i = 0; i < 16; i++)
         pix(8'h9F, 1'b1, 1'b1, (i % 3) == 2);
      pix(8'h9F, 1'b0, 1'b0, 1'b0);
      pix(8'h9F, 1'b1, 1'b0, 1'b0);

      // Palette write coinciding with a lookup of the same entry, then reset
      pix(8'h06, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 24'h123456);
      pix(8'h06, 1'b1, 1'b0, 1'b0);
      pix(8'h06, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 24'h654321);
      pix(8'h06, 1'b1, 1'b0, 1'b0);
      pix(8'h06, 1'b1, 1'b0, 1'b0);

      // Reset while the blink phase is active
      pix(8'h9F, 1'b1, 1'b1, 1'b1);
      pix(8'h9F, 1'b1, 1'b1, 1'b1);
      pix(8'h9F, 1'b1, 1'b1, 1'b0);
      pix(8'h9F, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 8'h9F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 24'h0);
      pix(8'h9F, 1'b1, 1'b1, 1'b1);
      pix(8'h9F, 1'b1, 1'b1, 1'b0);
      pix(8'h9F, 1'b1, 1'b1, 1'b0);

      // Random traffic including palette writes and frame pulses
      for (int i = 0; i < 300; i++)
         cyc(1'b0, 8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
             1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
             ($urandom_range(0, 9) == 0), 4'($urandom), 24'($urandom));

      for (int i = 0; i < 3; i++)
         cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cga_palette.md
Name: cga_palette

Overview:
- Parametrised successor to the fixed IRGB colour stage.
- Takes a per-pixel 8-bit attribute (bg nibble [7:4], fg nibble [3:0]) and a pixel-on bit, selects the fg or bg index, and looks it up in a 16-entry 24-bit RGB palette.
- Truncates each palette channel to the panel widths.
- Supports CGA text blink mode and carries DE/HS/VS through the pipeline so colour and sync stay aligned at the LCD.

Parameters:
- R_W, 5, red output width (1..8)
- G_W, 6, green output width (1..8)
- B_W, 5, blue output width (1..8)
- BLINK_FRAMES, 16, frame_i pulses per blink half-period (>=1)

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, synchronous, active-high
- color_i  in  8  attribute: [7:4] bg index, [3:0] fg index
- on_i  in  1  pixel on (fg) / off (bg), sampled with color_i
- de_i  in  1  display enable
- hs_i  in  1  hsync
- vs_i  in  1  vsync
- frame_i  in  1  one-cycle pulse, once per frame
- blink_mode_i  in  1  1 = attribute bit 7 is blink flag
- pal_we_i  in  1  palette write strobe
- pal_addr_i  in  4  palette write index
- pal_data_i  in  24  {R8,G8,B8}
- red_o  out  R_W
- green_o  out  G_W
- blue_o  out  B_W
- de_o  out  1  de_i delayed 2
- hs_o  out  1  hs_i delayed 2
- vs_o  out  1  vs_i delayed 2

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Latency: exactly 2 clk_i cycles from color_i/on_i/de_i/hs_i/vs_i to the outputs. All inputs are registered together, so on_i is no longer used asynchronously.
- Stage 1 (register):
  - attr, on, de, hs, vs.
  - Compute idx:
    - blink_mode_i=0: idx = on ? attr[3:0] : attr[7:4].
    - blink_mode_i=1: bg = {1'b0, attr[6:4]}; fg = attr[3:0]. If attr[7] & blink_phase, idx = bg regardless of on; else idx = on ? fg : bg.
  - blink_mode_i is sampled in stage 1 with the pixel.
- Stage 2 (register):
  - rgb = pal[idx].
  - red_o = rgb[23 -: R_W], green_o = rgb[15 -: G_W], blue_o = rgb[7 -: B_W] (MSB truncation).
  - When stage-1 de = 0, colour outputs are 0.
- Blink counter:
  - blink_cnt counts frame_i pulses from 0 to BLINK_FRAMES-1.
  - On a pulse at BLINK_FRAMES-1: blink_cnt wraps to 0 and blink_phase toggles.
  - BLINK_FRAMES=1 toggles the phase every frame.
  - The phase is updated regardless of blink_mode_i.
- Palette:
  - 16 x 24-bit registers. A write occurs on pal_we_i at the clock edge.
  - A lookup of the same index in the same cycle returns the old value (read-before-write); the new value is visible from the next cycle.
- Reset: red_o/green_o/blue_o = 0, de_o/hs_o/vs_o = 0, all pipeline registers = 0, blink_cnt = 0, blink_phase = 0, palette = default CGA table.
  - Reset mid-frame or mid-write: the write is dropped and the table returns to default.
- Default palette (hex RGB), idx 0..15: 000000, 0000AA, 00AA00, 00AAAA, AA0000, AA00AA, AA5500 (brown), AAAAAA, 555555, 5555FF, 55FF55, 55FFFF, FF5555, FF55FF, FFFF55, FFFFFF.

Optional Feature:
- Macro CGA_PAL_WR_EN.
- Defined: pal_we_i/pal_addr_i/pal_data_i are functional as described.
- Undefined: the ports still exist but are ignored. The palette is the constant default table (LUT/ROM, no registers), and reset has no palette effect.

Decomposition:
- Package cga_pkg:
  - CGA_DEFAULT_PAL (16 x 24-bit constant)
  - RGB888 typedef
  - attribute field index constants (BG_MSB=7, FG_MSB=3, BLINK_BIT=7)
- One sub-module: cga_blink_ctr (blink_cnt, blink_phase, BLINK_FRAMES parameter).
- The palette stays inline.

Test Plan:
- Reset, then color_i=8'h1E, on_i=1, de_i=1 → 2 cycles later rgb888 = FFFF55, so red_o=5'h1F, green_o=6'h3F, blue_o=5'h0A. With on_i=0 → 0000AA, so blue_o=5'h15, red_o=green_o=0.
- Sync alignment: de/hs/vs pattern 1,0,1,1,0 → de_o/hs_o/vs_o show the identical pattern shifted exactly 2 cycles. de_i=0 with color 8'hFF → rgb outputs 0.
- Blink: blink_mode_i=1, BLINK_FRAMES=2, color_i=8'h9F, on_i=1.
  - Frames 0–1: output FFFFFF.
  - After the 2nd frame_i pulse: output 0000AA (bg idx 1).
  - After the 4th pulse: back to FFFFFF.
  - Same attribute with blink_mode_i=0 → bg idx 9 used when on_i=0.
- Palette write (CGA_PAL_WR_EN): write idx 6 = 123456 while displaying idx 6 in the same cycle → first pixel shows AA5500, next shows 123456. Then assert rst_i → idx 6 reads AA5500.
- Reset mid-blink: blink_phase=1, assert rst_i for 1 cycle → blink_phase=0, blink_cnt=0, all outputs 0 in the following cycle.
- Width parameters R_W=G_W=B_W=8 → outputs equal the palette bytes exactly. R_W=1 → red_o = rgb[23].
